tmds_lock_supervisor: RTL and testbench

- Sits between the TMDS PLL and everything clocked from it.
- Watches the PLL lock output, qualifies it as stable, then releases resets in order:
  - first the CLKDIV/OSER10 serializer domain,
  - then the pixel-domain logic.
- On loss of lock it re-asserts both resets at once.
- If lock never arrives within a timeout, it pulses the PLL reset.

---
 rtl/tmds_sup_pkg.sv | 44 ++++
 rtl/tmds_sync2.sv | 23 ++
 rtl/tmds_lock_supervisor.sv | 174 +++++++++++++++++
 tb/tb_tmds_lock_supervisor.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/tmds_sup_pkg.sv
// Shared types and constants for the TMDS PLL lock supervisor: FSM states,
// per-state output encodings and counter sizing helpers.
package tmds_sup_pkg;

  typedef enum logic [2:0] {
    WAIT_LOCK   = 3'd0,
    STABLE      = 3'd1,
    RELEASE_DIV = 3'd2,
    RUN         = 3'd3,
    PLL_RST     = 3'd4
  } sup_state_e;

  typedef struct packed {
    logic clkdiv_rst;
    logic pix_rst;
    logic ready;
    logic pll_reset;
  } sup_out_t;

  localparam sup_out_t OUT_HOLD = 4'b1100;
  localparam sup_out_t OUT_DIV  = 4'b0100;
  localparam sup_out_t OUT_RUN  = 4'b0010;
  localparam sup_out_t OUT_PLL  = 4'b1101;

  localparam int RELOCK_CNT_W = 8;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic sup_out_t state_outputs(input sup_state_e st);
    sup_out_t o;
    case (st)
      WAIT_LOCK:   o = OUT_HOLD;
      STABLE:      o = OUT_HOLD;
      RELEASE_DIV: o = OUT_DIV;
      RUN:         o = OUT_RUN;
      PLL_RST:     o = OUT_PLL;
      default:     o = OUT_HOLD;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/tmds_sync2.sv
// Two-flop synchronizer for a single asynchronous status bit; the second
// stage is the only output that may be used by downstream logic.
module tmds_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  (* ASYNC_REG = "TRUE" *) logic [1:0] sync_r;

  // Shift the async input through two metastability-hardened stages.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_r <= 2'b00;
    end else begin
      sync_r <= {sync_r[0], d};
    end
  end

  assign q = sync_r[1];

endmodule

// File: rtl/tmds_lock_supervisor.sv
// Qualifies PLL lock, then sequences serializer and pixel reset release.
// Optional relock event counter is enabled by TMDS_SUP_RELOCK_CNT_EN.
module tmds_lock_supervisor
  import tmds_sup_pkg::*;
#(
  parameter int LOCK_STABLE_CYCLES  = 2700,
  parameter int LOCK_TIMEOUT_CYCLES = 270000,
  parameter int PLL_RST_CYCLES      = 27,
  parameter int DIV_TO_PIX_CYCLES   = 16
) (
  input  logic                    I_clk,
  input  logic                    I_rst,
  input  logic                    I_pll_lock,
  output logic                    O_pll_reset,
  output logic                    O_clkdiv_rst,
  output logic                    O_pix_rst,
  output logic                    O_ready,
  output logic [RELOCK_CNT_W-1:0] O_relock_cnt
);

  localparam int STB_W = cnt_width(LOCK_STABLE_CYCLES);
  localparam int TMO_W = cnt_width(LOCK_TIMEOUT_CYCLES);
  localparam int PLL_W = cnt_width(PLL_RST_CYCLES);
  localparam int DIV_W = cnt_width(DIV_TO_PIX_CYCLES);

  localparam logic [STB_W-1:0] STB_LAST = STB_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [PLL_W-1:0] PLL_LAST = PLL_W'(PLL_RST_CYCLES - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV_TO_PIX_CYCLES - 1);
  localparam logic [STB_W-1:0] STB_ONE  = STB_W'(1);
  localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);
  localparam logic [PLL_W-1:0] PLL_ONE  = PLL_W'(1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

  logic             lock_s;
  sup_state_e       state_r;
  sup_state_e       state_next_s;
  logic [STB_W-1:0] stb_cnt_r;
  logic [STB_W-1:0] stb_next_s;
  logic [TMO_W-1:0] tmo_cnt_r;
  logic [TMO_W-1:0] tmo_next_s;
  logic [PLL_W-1:0] pll_cnt_r;
  logic [PLL_W-1:0] pll_next_s;
  logic [DIV_W-1:0] div_cnt_r;
  logic [DIV_W-1:0] div_next_s;
  sup_out_t         out_r;

  tmds_sync2 u_lock_sync (
    .clk (I_clk),
    .rst (I_rst),
    .d   (I_pll_lock),
    .q   (lock_s)
  );

  // Next-state and counter decode; timeout has priority over lock events.
  always_comb begin
    state_next_s = state_r;
    stb_next_s   = stb_cnt_r;
    tmo_next_s   = tmo_cnt_r;
    pll_next_s   = pll_cnt_r;
    div_next_s   = div_cnt_r;
    case (state_r)
      WAIT_LOCK: begin
        if (tmo_cnt_r == TMO_LAST) begin
          state_next_s = PLL_RST;
          pll_next_s   = {PLL_W{1'b0}};
        end else begin
          tmo_next_s = tmo_cnt_r + TMO_ONE;
          if (lock_s) begin
            state_next_s = STABLE;
            stb_next_s   = {STB_W{1'b0}};
          end else begin
            state_next_s = WAIT_LOCK;
          end
        end
      end
      STABLE: begin
        // A bouncing lock keeps accumulating timeout across re-entries.
        if (tmo_cnt_r == TMO_LAST) begin
          state_next_s = PLL_RST;
          pll_next_s   = {PLL_W{1'b0}};
        end else begin
          tmo_next_s = tmo_cnt_r + TMO_ONE;
          if (!lock_s) begin
            state_next_s = WAIT_LOCK;
          end else if (stb_cnt_r == STB_LAST) begin
            state_next_s = RELEASE_DIV;
            div_next_s   = {DIV_W{1'b0}};
          end else begin
            stb_next_s = stb_cnt_r + STB_ONE;
          end
        end
      end
      RELEASE_DIV: begin
        if (!lock_s) begin
          state_next_s = WAIT_LOCK;
          tmo_next_s   = {TMO_W{1'b0}};
        end else if (div_cnt_r == DIV_LAST) begin
          state_next_s = RUN;
        end else begin
          div_next_s = div_cnt_r + DIV_ONE;
        end
      end
      RUN: begin
        if (!lock_s) begin
          state_next_s = WAIT_LOCK;
          tmo_next_s   = {TMO_W{1'b0}};
        end else begin
          state_next_s = RUN;
        end
      end
      PLL_RST: begin
        if (pll_cnt_r == PLL_LAST) begin
          state_next_s = WAIT_LOCK;
          tmo_next_s   = {TMO_W{1'b0}};
        end else begin
          pll_next_s = pll_cnt_r + PLL_ONE;
        end
      end
      default: begin
        state_next_s = WAIT_LOCK;
        tmo_next_s   = {TMO_W{1'b0}};
      end
    endcase
  end

  // State, counters and outputs all load on the same edge from the decode.
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      state_r   <= WAIT_LOCK;
      stb_cnt_r <= {STB_W{1'b0}};
      tmo_cnt_r <= {TMO_W{1'b0}};
      pll_cnt_r <= {PLL_W{1'b0}};
      div_cnt_r <= {DIV_W{1'b0}};
      out_r     <= OUT_HOLD;
    end else begin
      state_r   <= state_next_s;
      stb_cnt_r <= stb_next_s;
      tmo_cnt_r <= tmo_next_s;
      pll_cnt_r <= pll_next_s;
      div_cnt_r <= div_next_s;
      out_r     <= state_outputs(state_next_s);
    end
  end

  assign O_clkdiv_rst = out_r.clkdiv_rst;
  assign O_pix_rst    = out_r.pix_rst;
  assign O_ready      = out_r.ready;
  assign O_pll_reset  = out_r.pll_reset;

`ifdef TMDS_SUP_RELOCK_CNT_EN
  localparam logic [RELOCK_CNT_W-1:0] RELOCK_MAX = {RELOCK_CNT_W{1'b1}};
  localparam logic [RELOCK_CNT_W-1:0] RELOCK_ONE = RELOCK_CNT_W'(1);

  logic [RELOCK_CNT_W-1:0] relock_cnt_r;

  // Count RUN-to-WAIT_LOCK drops, saturating rather than wrapping.
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      relock_cnt_r <= {RELOCK_CNT_W{1'b0}};
    end else if ((state_r == RUN) && (state_next_s == WAIT_LOCK)
                 && (relock_cnt_r != RELOCK_MAX)) begin
      relock_cnt_r <= relock_cnt_r + RELOCK_ONE;
    end else begin
      relock_cnt_r <= relock_cnt_r;
    end
  end

  assign O_relock_cnt = relock_cnt_r;
`else
  assign O_relock_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_tmds_lock_supervisor.sv
// Directed bench for tmds_lock_supervisor with shortened timing parameters;
// relock expectations follow TMDS_SUP_RELOCK_CNT_EN.
module tb_tmds_lock_supervisor;

`ifdef TMDS_SUP_RELOCK_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic       lock;
  logic       pll_reset;
  logic       clkdiv_rst;
  logic       pix_rst;
  logic       ready;
  logic [7:0] relock_cnt;
  logic [3:0] outs;

  int checks;
  int failures;
  int edge_i;

  assign outs = {clkdiv_rst, pix_rst, ready, pll_reset};

  tmds_lock_supervisor #(
    .LOCK_STABLE_CYCLES  (8),
    .LOCK_TIMEOUT_CYCLES (64),
    .PLL_RST_CYCLES      (4),
    .DIV_TO_PIX_CYCLES   (4)
  ) dut (
    .I_clk        (clk),
    .I_rst        (rst),
    .I_pll_lock   (lock),
    .O_pll_reset  (pll_reset),
    .O_clkdiv_rst (clkdiv_rst),
    .O_pix_rst    (pix_rst),
    .O_ready      (ready),
    .O_relock_cnt (relock_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s edge=%0d got=%0h exp=%0h", tag, edge_i, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    edge_i++;
  endtask

  task automatic run_to(input int n);
    while (edge_i < n) step();
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    lock = 1'b0;
    step();
    step();
    rst    = 1'b0;
    edge_i = 0;
  endtask

  task automatic wait_outs(input string tag, input logic [3:0] mask,
                           input logic [3:0] want, input int budget);
    int  n;
    logic ok;
    n  = 0;
    ok = ((outs & mask) == want);
    while (!ok && n < budget) begin
      step();
      n++;
      ok = ((outs & mask) == want);
    end
    check_eq(tag, {31'd0, ok}, 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog edge=%0d", edge_i);
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks   = 0;
    failures = 0;
    edge_i   = 0;
    rst      = 1'b1;
    lock     = 1'b0;

    // reset values
    do_reset();
    check_eq("rst_outs", {28'd0, outs}, 32'hC);
    check_eq("rst_cnt", {24'd0, relock_cnt}, 32'd0);

    // clean lock sampled at edge 10
    do_reset();
    run_to(9);
    lock = 1'b1;
    run_to(19); check_eq("clean_e19", {28'd0, outs}, 32'hC);
    run_to(20); check_eq("clean_e20", {28'd0, outs}, 32'h4);
    run_to(23); check_eq("clean_e23", {28'd0, outs}, 32'h4);
    run_to(24); check_eq("clean_e24", {28'd0, outs}, 32'h2);

    // bounce: high at 10..14, low at 15, high from 16
    do_reset();
    run_to(9);  lock = 1'b1;
    run_to(14); lock = 1'b0;
    run_to(15); lock = 1'b1;
    run_to(20); check_eq("bnc_e20", {28'd0, outs}, 32'hC);
    run_to(25); check_eq("bnc_e25", {28'd0, outs}, 32'hC);
    run_to(26); check_eq("bnc_e26", {28'd0, outs}, 32'h4);
    run_to(29); check_eq("bnc_e29", {28'd0, outs}, 32'h4);
    run_to(30); check_eq("bnc_e30", {28'd0, outs}, 32'h2);

    // loss in RUN, lock sampled low at edge 33
    run_to(32); lock = 1'b0;
    run_to(34);
    check_eq("loss_e34", {28'd0, outs}, 32'h2);
    check_eq("loss_cnt0", {24'd0, relock_cnt}, 32'd0);
    run_to(35);
    check_eq("loss_e35", {28'd0, outs}, 32'hC);
    check_eq("loss_cnt1", {24'd0, relock_cnt}, CNT_EN ? 32'd1 : 32'd0);

    // no lock: PLL reset pulses
    do_reset();
    run_to(63);  check_eq("nl_e63", {28'd0, outs}, 32'hC);
    run_to(64);  check_eq("nl_e64", {28'd0, outs}, 32'hD);
    run_to(67);  check_eq("nl_e67", {28'd0, outs}, 32'hD);
    run_to(68);  check_eq("nl_e68", {28'd0, outs}, 32'hC);
    run_to(131); check_eq("nl_e131", {28'd0, outs}, 32'hC);
    run_to(132); check_eq("nl_e132", {28'd0, outs}, 32'hD);
    run_to(135); check_eq("nl_e135", {28'd0, outs}, 32'hD);
    run_to(136); check_eq("nl_e136", {28'd0, outs}, 32'hC);

    // relock saturation over 300 RUN drops
    do_reset();
    for (int i = 0; i < 300; i++) begin
      lock = 1'b1;
      wait_outs("sat_up", 4'b0010, 4'b0010, 40);
      lock = 1'b0;
      wait_outs("sat_dn", 4'b1000, 4'b1000, 8);
      if (i == 0)   check_eq("sat_cnt1", {24'd0, relock_cnt}, CNT_EN ? 32'd1 : 32'd0);
      if (i == 254) check_eq("sat_cnt255", {24'd0, relock_cnt}, CNT_EN ? 32'd255 : 32'd0);
    end
    check_eq("sat_cnt_end", {24'd0, relock_cnt}, CNT_EN ? 32'd255 : 32'd0);

    // I_rst while in RELEASE_DIV
    lock = 1'b1;
    wait_outs("rd_enter", 4'b1100, 4'b0100, 40);
    step();
    check_eq("rd_state", {28'd0, outs}, 32'h4);
    rst = 1'b1;
    step();
    check_eq("rd_rst_outs", {28'd0, outs}, 32'hC);
    check_eq("rd_rst_cnt", {24'd0, relock_cnt}, 32'd0);
    rst    = 1'b0;
    edge_i = 0;
    run_to(10); check_eq("rd_e10", {28'd0, outs}, 32'hC);
    run_to(11); check_eq("rd_e11", {28'd0, outs}, 32'h4);
    run_to(15); check_eq("rd_e15", {28'd0, outs}, 32'h2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
